// File: rtl/z90_decode_pkg.sv
// Shared Z90 decode types: prefix pages, prefix byte values, assembler states
// and displacement sign-extension helpers.
package z90_decode_pkg;

  typedef enum logic [2:0] {
    PAGE_BASE = 3'd0,
    PAGE_CB   = 3'd1,
    PAGE_ED   = 3'd2,
    PAGE_DD   = 3'd3,
    PAGE_FD   = 3'd4,
    PAGE_DDCB = 3'd5,
    PAGE_FDCB = 3'd6
  } z90_page_e;

  localparam logic [7:0] PFX_CB = 8'hCB;
  localparam logic [7:0] PFX_ED = 8'hED;
  localparam logic [7:0] PFX_DD = 8'hDD;
  localparam logic [7:0] PFX_FD = 8'hFD;

  typedef enum logic [2:0] {
    ST_OPC      = 3'd0,
    ST_IDX      = 3'd1,
    ST_IDXCB_D  = 3'd2,
    ST_IDXCB_OP = 3'd3,
    ST_DISP     = 3'd4,
    ST_IMM_LO   = 3'd5,
    ST_IMM_HI   = 3'd6,
    ST_OUT      = 3'd7
  } z90_asm_state_e;

  // Widest legal displacement; callers cast the result down to their DISP_W.
  function automatic logic [31:0] sext8_to_w(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  function automatic logic [15:0] sext8_to_s16(input logic [7:0] b);
    return 16'(sext8_to_w(b));
  endfunction

endpackage

// File: rtl/z90_insn_assembler.sv
// Z90 front-end byte-stream assembler: walks prefix pages, gathers displacement
// and immediate bytes, and presents one registered instruction record.
module z90_insn_assembler
  import z90_decode_pkg::*;
#(
  parameter int DISP_W    = 16,
  parameter int PFX_CNT_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_byte,
  output logic [2:0]           lk_page,
  output logic [7:0]           lk_opcode,
  input  logic                 lk_has_disp,
  input  logic [1:0]           lk_imm_len,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           out_page,
  output logic [7:0]           out_opcode,
  output logic [DISP_W-1:0]    out_disp,
  output logic [15:0]          out_imm,
  output logic [3:0]           out_len,
  output logic [PFX_CNT_W-1:0] out_pfx_redundant
);

  z90_asm_state_e state_q, state_d;
  z90_page_e      page_q, page_d;
  logic [7:0]     opcode_q, opcode_d;
  logic [7:0]     disp_q, disp_d;
  logic [7:0]     imm_lo_q, imm_lo_d;
  logic [7:0]     imm_hi_q, imm_hi_d;
  logic [1:0]     imm_len_q, imm_len_d;
  logic [3:0]     len_q, len_d;
  logic [PFX_CNT_W-1:0] pfx_q, pfx_d;

  logic accept;
  logic take_opcode;
  logic pfx_inc;

  assign in_ready  = (state_q != ST_OUT);
  assign accept    = in_valid && in_ready;
  assign lk_page   = page_q;
  assign lk_opcode = in_byte;

  always_comb begin
    state_d     = state_q;
    page_d      = page_q;
    opcode_d    = opcode_q;
    disp_d      = disp_q;
    imm_lo_d    = imm_lo_q;
    imm_hi_d    = imm_hi_q;
    imm_len_d   = imm_len_q;
    len_d       = len_q;
    pfx_d       = pfx_q;
    take_opcode = 1'b0;
    pfx_inc     = 1'b0;

    if (accept) begin
      len_d = (len_q == 4'hF) ? 4'hF : len_q + 4'd1;
    end

    case (state_q)
      ST_OPC: if (accept) begin
        if (page_q == PAGE_BASE && in_byte == PFX_CB) begin
          page_d = PAGE_CB;
        end else if (page_q == PAGE_BASE && in_byte == PFX_ED) begin
          page_d = PAGE_ED;
        end else if (page_q == PAGE_BASE && in_byte == PFX_DD) begin
          page_d  = PAGE_DD;
          state_d = ST_IDX;
        end else if (page_q == PAGE_BASE && in_byte == PFX_FD) begin
          page_d  = PAGE_FD;
          state_d = ST_IDX;
        end else begin
          take_opcode = 1'b1;
        end
      end
      ST_IDX: if (accept) begin
        // Only the last DD/FD before the opcode counts; earlier ones are redundant.
        if (in_byte == PFX_DD) begin
          page_d  = PAGE_DD;
          pfx_inc = 1'b1;
        end else if (in_byte == PFX_FD) begin
          page_d  = PAGE_FD;
          pfx_inc = 1'b1;
        end else if (in_byte == PFX_ED) begin
          page_d  = PAGE_ED;
          pfx_inc = 1'b1;
          state_d = ST_OPC;
        end else if (in_byte == PFX_CB) begin
          page_d  = (page_q == PAGE_DD) ? PAGE_DDCB : PAGE_FDCB;
          state_d = ST_IDXCB_D;
        end else begin
          take_opcode = 1'b1;
        end
      end
      ST_IDXCB_D: if (accept) begin
        disp_d  = in_byte;
        state_d = ST_IDXCB_OP;
      end
      ST_IDXCB_OP: if (accept) begin
        opcode_d = in_byte;
        state_d  = ST_OUT;
      end
      ST_DISP: if (accept) begin
        disp_d  = in_byte;
        state_d = (imm_len_q != 2'd0) ? ST_IMM_LO : ST_OUT;
      end
      ST_IMM_LO: if (accept) begin
        imm_lo_d = in_byte;
        state_d  = (imm_len_q == 2'd2) ? ST_IMM_HI : ST_OUT;
      end
      ST_IMM_HI: if (accept) begin
        imm_hi_d = in_byte;
        state_d  = ST_OUT;
      end
      ST_OUT: if (out_ready) begin
        state_d   = ST_OPC;
        page_d    = PAGE_BASE;
        opcode_d  = 8'h00;
        disp_d    = 8'h00;
        imm_lo_d  = 8'h00;
        imm_hi_d  = 8'h00;
        imm_len_d = 2'd0;
        len_d     = 4'd0;
        pfx_d     = '0;
      end
      default: state_d = ST_OPC;
    endcase

    if (pfx_inc && !(&pfx_q)) begin
      pfx_d = pfx_q + PFX_CNT_W'(1);
    end

    if (take_opcode) begin
      opcode_d  = in_byte;
      imm_len_d = (lk_imm_len == 2'd3) ? 2'd2 : lk_imm_len;
      if (lk_has_disp)               state_d = ST_DISP;
      else if (lk_imm_len != 2'd0)   state_d = ST_IMM_LO;
      else                           state_d = ST_OUT;
    end

    if (flush) begin
      state_d   = ST_OPC;
      page_d    = PAGE_BASE;
      opcode_d  = 8'h00;
      disp_d    = 8'h00;
      imm_lo_d  = 8'h00;
      imm_hi_d  = 8'h00;
      imm_len_d = 2'd0;
      len_d     = 4'd0;
      pfx_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_OPC;
      page_q    <= PAGE_BASE;
      opcode_q  <= 8'h00;
      disp_q    <= 8'h00;
      imm_lo_q  <= 8'h00;
      imm_hi_q  <= 8'h00;
      imm_len_q <= 2'd0;
      len_q     <= 4'd0;
      pfx_q     <= '0;
    end else begin
      state_q   <= state_d;
      page_q    <= page_d;
      opcode_q  <= opcode_d;
      disp_q    <= disp_d;
      imm_lo_q  <= imm_lo_d;
      imm_hi_q  <= imm_hi_d;
      imm_len_q <= imm_len_d;
      len_q     <= len_d;
      pfx_q     <= pfx_d;
    end
  end

  assign out_valid         = (state_q == ST_OUT);
  assign out_page          = page_q;
  assign out_opcode        = opcode_q;
  assign out_disp          = DISP_W'(sext8_to_w(disp_q));
  assign out_imm           = {imm_hi_q, imm_lo_q};
  assign out_len           = len_q;
  assign out_pfx_redundant = pfx_q;

endmodule
